// File: rtl/lcd_byte_sequencer_pkg.sv
// Shared definitions for the character-LCD byte sequencer: state encodings,
// byte payload type, init nibble list and configuration byte ROM.
package lcd_defs;

  localparam int unsigned NIB_W    = 4;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned TX_CNT_W = 8;
  localparam int unsigned N_INIT   = 4;
  localparam int unsigned N_CFG    = 4;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_INIT_WAIT,
    ST_CFG,
    ST_IDLE,
    ST_BYTE_HI,
    ST_NIB_GAP,
    ST_BYTE_LO,
    ST_BYTE_WAIT
  } seq_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_HIGH,
    TX_HOLD
  } tx_state_t;

  typedef struct packed {
    logic              rs;
    logic [BYTE_W-1:0] data;
  } lcd_byte_t;

  localparam logic [BYTE_W-1:0] CMD_CLEAR     = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_HOME      = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_HOME_ALT  = 8'h03;

  // Entry [0] is sent first.
  localparam logic [N_CFG-1:0][BYTE_W-1:0] CFG_ROM   = {8'h01, 8'h0C, 8'h06, 8'h28};
  localparam logic [N_INIT-1:0][NIB_W-1:0] INIT_NIBS = {4'h2, 4'h3, 4'h3, 4'h3};

  // Clear and Return Home need the long post-command wait.
  function automatic logic is_long_cmd(input lcd_byte_t b);
    return !b.rs && ((b.data == CMD_CLEAR) || (b.data == CMD_HOME) ||
                     (b.data == CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_byte_sequencer_nibble_tx.sv
// One timed 4-bit LCD write: data/RS set up, E strobe, one hold cycle.
// busy covers capture through hold; done pulses during the hold cycle.
module lcd_nibble_tx
  import lcd_defs::*;
#(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_E     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NIB_W-1:0] nib,
  input  logic             rs,
  output logic             busy,
  output logic             done,
  output logic [NIB_W-1:0] SF_D,
  output logic             LCD_E,
  output logic             LCD_RS
);

  tx_state_t             st_q, st_n;
  logic [TX_CNT_W-1:0]   cnt_q, cnt_n;
  logic [NIB_W-1:0]      sf_d_n;
  logic                  rs_n, e_n, busy_n, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= TX_IDLE;
      cnt_q  <= '0;
      SF_D   <= '0;
      LCD_RS <= 1'b0;
      LCD_E  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      st_q   <= st_n;
      cnt_q  <= cnt_n;
      SF_D   <= sf_d_n;
      LCD_RS <= rs_n;
      LCD_E  <= e_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  always_comb begin
    st_n   = st_q;
    cnt_n  = (cnt_q != '0) ? cnt_q - TX_CNT_W'(1) : cnt_q;
    sf_d_n = SF_D;
    rs_n   = LCD_RS;
    e_n    = 1'b0;
    busy_n = busy;
    done_n = 1'b0;
    case (st_q)
      TX_IDLE: begin
        if (start) begin
          st_n   = TX_SETUP;
          cnt_n  = TX_CNT_W'(T_SETUP - 1);
          sf_d_n = nib;
          rs_n   = rs;
          busy_n = 1'b1;
        end
      end
      TX_SETUP: begin
        if (cnt_q == '0) begin
          st_n  = TX_HIGH;
          cnt_n = TX_CNT_W'(T_E - 1);
          e_n   = 1'b1;
        end
      end
      TX_HIGH: begin
        if (cnt_q == '0) begin
          st_n   = TX_HOLD;
          done_n = 1'b1;
        end else begin
          e_n = 1'b1;
        end
      end
      TX_HOLD: begin
        st_n   = TX_IDLE;
        busy_n = 1'b0;
      end
      default: st_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_byte_sequencer.sv
// Sole driver of the Spartan-3E character LCD 4-bit bus: power-on init,
// configuration, then byte writes accepted over a valid/ready handshake.
module lcd_byte_sequencer
  import lcd_defs::*;
#(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_SHORT   = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_E       = 12,
  parameter int unsigned T_NIB     = 50,
  parameter int unsigned CNT_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic              wr_rs,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              init_done,
  output logic [NIB_W-1:0]  SF_D,
  output logic              LCD_E,
  output logic              LCD_RS,
  output logic              LCD_RW
);

  seq_state_t        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              armed_q, armed_n;
  logic [1:0]        init_idx_q, init_idx_n;
  logic [2:0]        cfg_idx_q, cfg_idx_n;
  lcd_byte_t         cur_q, cur_n;

  logic              tx_start_c;
  logic [NIB_W-1:0]  tx_nib_c;
  logic              tx_rs_c;
  logic              tx_busy, tx_done;

  // Delay that follows each of the four init nibbles.
  function automatic logic [CNT_W-1:0] init_wait(input logic [1:0] idx);
    case (idx)
      2'd0:    return CNT_W'(T_INIT1 - 1);
      2'd1:    return CNT_W'(T_INIT2 - 1);
      default: return CNT_W'(T_SHORT - 1);
    endcase
  endfunction

  assign LCD_RW = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PWR_WAIT;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      init_idx_q <= '0;
      cfg_idx_q  <= '0;
      cur_q      <= '0;
      wr_ready   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      armed_q    <= armed_n;
      init_idx_q <= init_idx_n;
      cfg_idx_q  <= cfg_idx_n;
      cur_q      <= cur_n;
      wr_ready   <= (state_n == ST_IDLE);
      init_done  <= init_done | (state_n == ST_IDLE);
    end
  end

  // Next-state, delay counter and nibble-start control. Timed waits issue
  // the next nibble start on their final count so no cycle is lost.
  always_comb begin
    state_n    = state_q;
    cnt_n      = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    armed_n    = armed_q;
    init_idx_n = init_idx_q;
    cfg_idx_n  = cfg_idx_q;
    cur_n      = cur_q;
    tx_start_c = 1'b0;
    tx_nib_c   = cur_q.data[7:4];
    tx_rs_c    = cur_q.rs;
    case (state_q)
      ST_PWR_WAIT: begin
        if (!armed_q) begin
          armed_n = 1'b1;
          cnt_n   = CNT_W'(T_POWERUP - 1);
        end else if (cnt_q == '0) begin
          tx_start_c = 1'b1;
          tx_nib_c   = INIT_NIBS[init_idx_q];
          tx_rs_c    = 1'b0;
          state_n    = ST_INIT;
        end
      end
      ST_INIT: begin
        if (tx_done) begin
          cnt_n   = init_wait(init_idx_q);
          state_n = ST_INIT_WAIT;
        end
      end
      ST_INIT_WAIT: begin
        if (cnt_q == '0) begin
          if (init_idx_q == 2'(N_INIT - 1)) begin
            state_n = ST_CFG;
          end else begin
            init_idx_n = init_idx_q + 2'd1;
            tx_start_c = 1'b1;
            tx_nib_c   = INIT_NIBS[init_idx_q + 2'd1];
            tx_rs_c    = 1'b0;
            state_n    = ST_INIT;
          end
        end
      end
      ST_CFG: begin
        cur_n.rs   = 1'b0;
        cur_n.data = CFG_ROM[cfg_idx_q[1:0]];
        cfg_idx_n  = cfg_idx_q + 3'd1;
        state_n    = ST_BYTE_HI;
      end
      ST_IDLE: begin
        if (wr_valid) begin
          cur_n.rs   = wr_rs;
          cur_n.data = wr_data;
          state_n    = ST_BYTE_HI;
        end
      end
      ST_BYTE_HI: begin
        tx_start_c = ~tx_busy;
        if (tx_done) begin
          cnt_n   = CNT_W'(T_NIB - 1);
          state_n = ST_NIB_GAP;
        end
      end
      ST_NIB_GAP: begin
        if (cnt_q == '0) begin
          tx_start_c = 1'b1;
          tx_nib_c   = cur_q.data[3:0];
          state_n    = ST_BYTE_LO;
        end
      end
      ST_BYTE_LO: begin
        if (tx_done) begin
          cnt_n   = is_long_cmd(cur_q) ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_SHORT - 1);
          state_n = ST_BYTE_WAIT;
        end
      end
      ST_BYTE_WAIT: begin
        if (cnt_q == '0) begin
          state_n = (!init_done && (cfg_idx_q != 3'(N_CFG))) ? ST_CFG : ST_IDLE;
        end
      end
      default: state_n = ST_PWR_WAIT;
    endcase
  end

  lcd_nibble_tx #(
    .T_SETUP (T_SETUP),
    .T_E     (T_E)
  ) u_nibble_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (tx_start_c),
    .nib    (tx_nib_c),
    .rs     (tx_rs_c),
    .busy   (tx_busy),
    .done   (tx_done),
    .SF_D   (SF_D),
    .LCD_E  (LCD_E),
    .LCD_RS (LCD_RS)
  );

endmodule
